// File: rtl/fg_cfg_dac_if_if.sv
// Host register-write bus and generator/DAC strobe signals of the function
// generator configuration front end.
interface fg_cfg_dac_if_if #(
  parameter int NUM_REGS   = 8,
  parameter int REG_WIDTH  = 8,
  parameter int ADDR_WIDTH = 3
) ();
  logic [REG_WIDTH-1:0]          data_i;
  logic [ADDR_WIDTH-1:0]         addr_i;
  logic                          wr_en_async_i;
  logic [NUM_REGS*REG_WIDTH-1:0] cr_bus_o;
  logic                          cr_update_o;
  logic                          addr_err_o;
  logic                          sample_valid_i;
  logic                          dac_wr_n_o;
  logic                          dac_busy_o;
  logic                          overrun_o;

  modport slave (
    input  data_i, addr_i, wr_en_async_i, sample_valid_i,
    output cr_bus_o, cr_update_o, addr_err_o, dac_wr_n_o, dac_busy_o, overrun_o
  );

  modport master (
    output data_i, addr_i, wr_en_async_i, sample_valid_i,
    input  cr_bus_o, cr_update_o, addr_err_o, dac_wr_n_o, dac_busy_o, overrun_o
  );
endinterface

// File: rtl/fg_cfg_dac_if.sv
// Configuration shadow/active register bank with synchronised host writes, and
// sample-strobe to active-low DAC write pulse converter with a one-deep queue.
module fg_cfg_dac_if #(
  parameter int NUM_REGS    = 8,
  parameter int REG_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int STRB_WIDTH  = 2,
  parameter int STRB_GAP    = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  fg_cfg_dac_if_if.slave bus
);
  localparam int CMAX = (STRB_WIDTH > STRB_GAP) ? STRB_WIDTH : STRB_GAP;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0]       W_LAST = CW'(STRB_WIDTH - 1);
  localparam logic [CW-1:0]       G_LAST = (STRB_GAP > 0) ? CW'(STRB_GAP - 1) : '0;
  localparam logic [ADDR_WIDTH:0] NREGS  = (ADDR_WIDTH + 1)'(NUM_REGS);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_prime;
  logic                   r_sync_d;
  logic                   w_sync;
  logic                   w_wr_pulse;
  logic                   w_addr_ok;
  logic                   w_commit;
  logic [REG_WIDTH-1:0]   r_shadow [NUM_REGS];
  logic [REG_WIDTH-1:0]   r_active [NUM_REGS];
  logic [REG_WIDTH-1:0]   w_shadow_nxt [NUM_REGS];
  logic                   r_update;
  logic                   r_addr_err;
  logic [NUM_REGS*REG_WIDTH-1:0] w_cr_bus;

  assign w_sync     = r_sync[SYNC_STAGES-1];
  assign w_wr_pulse = w_sync & ~r_sync_d;
  assign w_addr_ok  = {1'b0, bus.addr_i} < NREGS;
  assign w_commit   = w_wr_pulse & (bus.addr_i == ADDR_WIDTH'(NUM_REGS - 1));

  // History is held high until the synchroniser has filled after reset, so an
  // enable that was already high at reset release is never seen as an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync   <= '0;
      r_prime  <= '0;
      r_sync_d <= 1'b1;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], bus.wr_en_async_i};
      r_prime  <= {r_prime[SYNC_STAGES-2:0], 1'b1};
      r_sync_d <= w_sync | ~r_prime[SYNC_STAGES-1];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_shadow_nxt[i] = (w_wr_pulse && bus.addr_i == ADDR_WIDTH'(i)) ? bus.data_i : r_shadow[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_update   <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_shadow <= w_shadow_nxt;
      if (w_commit) r_active <= w_shadow_nxt;
      r_update <= w_commit;
      if (w_wr_pulse && !w_addr_ok) r_addr_err <= 1'b1;
    end
  end

  always_comb begin
    w_cr_bus = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_cr_bus[(NUM_REGS-1-i)*REG_WIDTH +: REG_WIDTH] = r_active[i];
    end
  end

  assign bus.cr_bus_o    = w_cr_bus;
  assign bus.cr_update_o = r_update;
  assign bus.addr_err_o  = r_addr_err;

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_pending, w_pending_nxt;
  logic            r_overrun, w_overrun_nxt;
  logic            r_wr_n;
  logic            w_end;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_wr_n    <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= w_pending_nxt;
      r_overrun <= w_overrun_nxt;
      r_wr_n    <= (w_state_nxt != S_PULSE);
    end
  end

  // w_end marks the last cycle of a pulse+gap slot, where a queued or
  // simultaneous sample may start the next pulse back to back.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pending_nxt = r_pending;
    w_overrun_nxt = r_overrun;
    w_end         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.sample_valid_i) begin
          w_state_nxt = S_PULSE;
          w_cnt_nxt   = '0;
        end
      end
      S_PULSE: begin
        if (r_cnt == W_LAST) begin
          w_cnt_nxt = '0;
          if (STRB_GAP > 0) w_state_nxt = S_GAP;
          else              w_end       = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == G_LAST) begin
          w_cnt_nxt = '0;
          w_end     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_end) w_state_nxt = (r_pending || bus.sample_valid_i) ? S_PULSE : S_IDLE;

    if (r_state != S_IDLE && bus.sample_valid_i) begin
      if (!w_end) begin
        if (r_pending) w_overrun_nxt = 1'b1;
        w_pending_nxt = 1'b1;
      end
    end else if (w_end) begin
      w_pending_nxt = 1'b0;
    end
  end

  assign bus.dac_wr_n_o = r_wr_n;
  assign bus.dac_busy_o = (r_state != S_IDLE) | r_pending;
  assign bus.overrun_o  = r_overrun;
endmodule
